// File: rtl/datapath_decode.sv
// Decode / register-read stage: regfile, load-use stall, flush squash, ID/EX register.
// Optional macro DECODE_WB_BYPASS_EN: same-cycle writeback forwarding into read ports.
module datapath_decode #(
    parameter int IF_ID_WIDTH = 33,
    parameter int ID_EX_WIDTH = 70
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IF_ID_WIDTH-1:0] IF_ID,
    input  logic                   wb_en,
    input  logic [2:0]             wb_reg,
    input  logic [15:0]            wb_data,
    input  logic                   flush,
    output logic                   PCwrite,
    output logic                   if_id_hold,
    output logic [ID_EX_WIDTH-1:0] ID_EX
);

    logic [15:0] regs [8];

    logic        if_valid;
    logic [15:0] if_pc;
    logic [15:0] instr;
    logic [3:0]  op;
    logic        imm;
    logic [2:0]  rx;
    logic [2:0]  ry;

    logic [15:0] rx_val;
    logic [15:0] ry_val;
    logic        is_load;
    logic        wr_en;
    logic [2:0]  rd;

    logic        ex_valid;
    logic        ex_load;
    logic [2:0]  ex_rd;
    logic        stall;
    logic        stall_eff;

    logic [ID_EX_WIDTH-1:0] id_ex_d;

    assign if_valid = IF_ID[32];
    assign if_pc    = IF_ID[31:16];
    assign instr    = IF_ID[15:0];
    assign op       = instr[3:0];
    assign imm      = instr[4];
    assign rx       = instr[7:5];
    assign ry       = instr[10:8];

    assign ex_valid = ID_EX[69];
    assign ex_load  = ID_EX[4];
    assign ex_rd    = ID_EX[2:0];

    // Register read ports, optionally forwarding the writeback in flight.
    always_comb begin
        rx_val = regs[rx];
        ry_val = regs[ry];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (wb_reg == rx)) rx_val = wb_data;
        if (wb_en && (wb_reg == ry)) ry_val = wb_data;
`endif
    end

    // Destination decode: ALU/load ops write Rx, call writes the link register r7.
    always_comb begin
        is_load = 1'b0;
        wr_en   = 1'b0;
        rd      = 3'd0;
        unique case (op)
            4'h0, 4'h1, 4'h2, 4'h6: begin
                wr_en = 1'b1;
                rd    = rx;
            end
            4'h4: begin
                is_load = 1'b1;
                wr_en   = 1'b1;
                rd      = rx;
            end
            4'hC: begin
                wr_en = 1'b1;
                rd    = 3'd7;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Load-use hazard against the load now in execute; flush overrides it.
    always_comb begin
        stall = ~reset & if_valid & ex_valid & ex_load
              & ((ex_rd == rx) | ((ex_rd == ry) & ~imm));
        stall_eff  = stall & ~flush;
        PCwrite    = ~stall_eff;
        if_id_hold = stall_eff;
    end

    // Next ID/EX contents: bubble on flush, stall or empty slot.
    always_comb begin
        id_ex_d = '0;
        if (if_valid && !flush && !stall) begin
            id_ex_d = {1'b1, if_pc, instr, rx_val, ry_val,
                       is_load, wr_en, rd};
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (reset) ID_EX <= '0;
        else       ID_EX <= id_ex_d;
    end

    // Register file write port, driven by writeback regardless of stall/flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (wb_en) begin
            regs[wb_reg] <= wb_data;
        end
    end

endmodule

// File: doc/datapath_decode.md
# datapath_decode

Instruction-decode / register-read stage of the 16-bit pipelined datapath, sitting directly downstream of fetch. Consumes the IF/ID pipeline register {valid, PC+2, instruction}, reads the 8x16 register file, detects load-use hazards and stalls fetch, squashes on taken branches, and produces the ID/EX pipeline register for execute. Owns the register file; writeback drives its write port.

## Interface
- IF_ID_WIDTH, 33, IF/ID width: [32] valid, [31:16] PC+2, [15:0] instruction
- ID_EX_WIDTH, 70, ID/EX width (layout under Operation)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- IF_ID  in  IF_ID_WIDTH  fetch pipeline register
- wb_en  in  1  register-file write enable from writeback
- wb_reg  in  3  write register index
- wb_data  in  16  write data
- flush  in  1  branch taken in execute; squash instruction in decode
- PCwrite  out  1  fetch PC advance enable
- if_id_hold  out  1  fetch must hold IF_ID this cycle
- ID_EX  out  ID_EX_WIDTH  decode pipeline register

## Operation
- Fields: op=instr[3:0], imm=instr[4], Rx=instr[7:5], Ry=instr[10:8].
- ID_EX layout: [69] valid, [68:53] PC+2, [52:37] instr, [36:21] Rx value, [20:5] Ry value, [4] is_load, [3] wr_en, [2:0] rd.
- is_load: op==4'h4. wr_en: op in {0 mv, 1 add, 2 sub, 4 ld, 6 mvhi} with rd=Rx; op==4'hC (call) with rd=3'd7; otherwise wr_en=0, rd=0.
- Ry used only when imm==0. Rx always treated as used.
- Load-use stall (combinational): IF_ID[32] & ID_EX[69] & ID_EX[4] & (ID_EX[2:0]==Rx | (ID_EX[2:0]==Ry & ~imm)).
- On stall: PCwrite=0, if_id_hold=1, ID_EX loaded with bubble (all zeros). Stall lasts exactly one cycle, since the next ID_EX is a bubble.
- On flush: ID_EX loaded with bubble and the stall is suppressed (PCwrite=1, if_id_hold=0). Flush has priority over stall.
- IF_ID[32]==0: ID_EX loaded with bubble, no stall.
- Otherwise ID_EX loads the decoded fields with valid=1, and PC+2 and instr pass through unchanged.
- Register file: 8x16 flops. Written at posedge when wb_en. r0 is an ordinary register, not hardwired to zero.

## Timing
- Reset: ID_EX=0, all registers=0. During reset cycle PCwrite=1, if_id_hold=0.
- Latency: IF_ID sampled at edge N appears in ID_EX after edge N+1.
- Writeback in the same cycle as a read of the same register: see Configuration.
- wb_en during stall or flush still writes the register file.
- Reset asserted mid-stall clears ID_EX; the following cycle shows no stall.

## Configuration
- DECODE_WB_BYPASS_EN defined: read ports return wb_data when wb_en & wb_reg matches the read index, in the same cycle (write-before-read).
- Undefined: reads return the pre-write register value. Software must separate writeback and a dependent read by one instruction.

## Test plan
- Reset then IF_ID={1,16'h0002,add r1,r2 (16'h0221)}, r2=5 -> next cycle ID_EX valid=1, Rx val=0, Ry val=5, wr_en=1, rd=1, PCwrite=1.
- ld r3 then add r4,r3 back-to-back -> one cycle with PCwrite=0, if_id_hold=1, ID_EX bubble; add issues the following cycle; total one stall cycle.
- ld r3 then add-immediate r4 (imm=1) whose Ry field=3 -> no stall.
- Load-use stall coincident with flush=1 -> ID_EX bubble, PCwrite=1, if_id_hold=0.
- wb_en=1, wb_reg=2, wb_data=16'hBEEF while decoding an instruction that reads r2 -> Ry val=16'hBEEF with DECODE_WB_BYPASS_EN defined, old r2 value without it. The next instruction reading r2 gets 16'hBEEF in both builds.
- call in decode (op 4'hC) -> ID_EX wr_en=1, rd=7, PC+2 field equal to IF_ID[31:16].
